// File: rtl/inst_reload_if.sv
// Instruction stream input and byte-wide memory write port of the reload controller.
interface inst_reload_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  inst_valid;
    logic [15:0]           inst_data;
    logic                  inst_last;
    logic                  inst_ready;
    logic                  mem_sel;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_dataout;
    logic                  mem_we;

    modport master (
        output inst_valid, inst_data, inst_last,
        input  inst_ready, mem_sel, mem_addr, mem_dataout, mem_we
    );

    modport slave (
        input  inst_valid, inst_data, inst_last,
        output inst_ready, mem_sel, mem_addr, mem_dataout, mem_we
    );
endinterface

// File: rtl/inst_reload_ctrl.sv
// Reloads 16-bit instructions into CPU byte memory and restarts the CPU.
// Optional HALT-word append after the last word: define RELOAD_HALT_APPEND_EN.
module inst_reload_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          BASE_ADDR  = 500,
    parameter int          MAX_WORDS  = 16,
    parameter logic [15:0] HALT_WORD  = 16'h0800
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   nxt,
    inst_reload_if.slave bus,
    output logic         cpu_start,
    output logic         busy,
    output logic         done,
    output logic         err_overflow
);
`ifdef RELOAD_HALT_APPEND_EN
    localparam bit APPEND = 1'b1;
`else
    localparam bit APPEND = 1'b0;
`endif
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, WR_LO, WR_HI, START, HALTED
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d, cnt_inc;
    logic [15:0]           word, word_d;
    logic                  last, last_d;
    logic                  app, app_d;
    logic                  err_d;
    logic                  nxt1_q;
    logic [ADDR_WIDTH-1:0] lo_addr;

    assign cnt_inc = cnt + CW'(1);
    // Address math is done at ADDR_WIDTH bits so it wraps naturally.
    assign lo_addr = BASE + (ADDR_WIDTH'(cnt) << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            word         <= '0;
            last         <= 1'b0;
            app          <= 1'b0;
            err_overflow <= 1'b0;
            nxt1_q       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            word         <= word_d;
            last         <= last_d;
            app          <= app_d;
            err_overflow <= err_d;
            nxt1_q       <= nxt[1];
        end
    end

    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        word_d          = word;
        last_d          = last;
        app_d           = app;
        err_d           = err_overflow;
        bus.inst_ready  = 1'b0;
        bus.mem_sel     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_dataout = '0;
        cpu_start       = 1'b0;
        busy            = (state != IDLE) && (state != HALTED);
        done            = (state == HALTED);
        unique case (state)
            IDLE: begin
                if (nxt[0]) begin
                    state_d = HALTED;
                end else if (nxt[1] && !nxt1_q) begin
                    state_d = WAIT_DATA;
                    cnt_d   = '0;
                    app_d   = 1'b0;
                end
            end
            WAIT_DATA: begin
                bus.inst_ready = 1'b1;
                bus.mem_sel    = 1'b1;
                if (bus.inst_valid) begin
                    word_d  = bus.inst_data;
                    last_d  = bus.inst_last;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                bus.mem_sel     = 1'b1;
                bus.mem_we      = 1'b1;
                bus.mem_addr    = lo_addr;
                bus.mem_dataout = word[7:0];
                state_d         = WR_HI;
            end
            WR_HI: begin
                bus.mem_sel     = 1'b1;
                bus.mem_we      = 1'b1;
                bus.mem_addr    = lo_addr + ADDR_WIDTH'(1);
                bus.mem_dataout = word[15:8];
                cnt_d           = cnt_inc;
                if (app) begin
                    state_d = START;
                end else if (last) begin
                    if (!APPEND) begin
                        state_d = START;
                    end else if (cnt_inc < CNT_MAX) begin
                        word_d  = HALT_WORD;
                        app_d   = 1'b1;
                        state_d = WR_LO;
                    end else begin
                        err_d   = 1'b1;
                        state_d = START;
                    end
                end else if (cnt_inc == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = START;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            START: begin
                cpu_start = 1'b1;
                state_d   = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_inst_reload_ctrl.sv
// Randomized bench for inst_reload_ctrl with a transaction-level reference model.
module tb_inst_reload_ctrl;
    localparam int          AW   = 10;
    localparam int          BASE = 500;
    localparam int          MAXW = 16;
    localparam logic [15:0] HALT = 16'h0800;
`ifdef RELOAD_HALT_APPEND_EN
    localparam bit APP = 1'b1;
`else
    localparam bit APP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] nxt = 2'b00;
    logic       cpu_start, busy, done, err_overflow;

    inst_reload_if #(.ADDR_WIDTH(AW)) bus ();

    inst_reload_ctrl #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nxt         (nxt),
        .bus         (bus.slave),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .done        (done),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    wr_t        expq[$];
    wr_t        e;
    int         k, n_start, n_pulse;
    bit         exp_err, err_pend, exp_halted, prev_we;
    logic [7:0] mem [0:1023];
    int         wgen[0:1023];
    int         gen;
    int         n_cmp, n_bad;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input int idx);
        expq.push_back({AW'(BASE + 2 * idx), w[7:0]});
        expq.push_back({AW'(BASE + 2 * idx + 1), w[15:8]});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_burst();
        nxt = 2'b10;
        cyc(1);
        nxt = 2'b00;
    endtask

    task automatic send(input logic [15:0] w, input bit lst, input int bound,
                        output bit ok);
        bus.inst_valid = 1'b1;
        bus.inst_data  = w;
        bus.inst_last  = lst;
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (bus.inst_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;
        bus.inst_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 40) begin
            cyc(1);
            t++;
        end
        chk("idle_reached", busy, 0);
        chk("no_pending_wr", expq.size(), 0);
        chk("no_pending_start", n_start, 0);
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_halted = 1'b0;
        nxt = 2'b00;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
    endtask

    logic [7:0] exp37[6];
    bit         ok;
    int         p0, cnt, len;
    bit         hl, lst;

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;
        bus.inst_last  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            wgen[i] = -1;
            mem[i]  = '0;
        end
        gen = 0;
        exp37 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    expq.delete();
                    n_start  = 0;
                    k        = 0;
                    exp_err  = 1'b0;
                    err_pend = 1'b0;
                    prev_we  = 1'b0;
                    chk("reset_outputs",
                        {bus.inst_ready, bus.mem_sel, bus.mem_we,
                         bus.mem_addr != 0, bus.mem_dataout != 0,
                         cpu_start, busy, done, err_overflow}, 0);
                end else begin
                    if (bus.inst_valid && bus.inst_ready) begin
                        push_word(bus.inst_data, k);
                        k++;
                        if (bus.inst_last) begin
                            if (APP) begin
                                if (k < MAXW) push_word(HALT, k);
                                else err_pend = 1'b1;
                            end
                            n_start++;
                            k = 0;
                        end else if (k == MAXW) begin
                            err_pend = 1'b1;
                            n_start++;
                            k = 0;
                        end
                    end
                    if (bus.mem_we) begin
                        chk("write_expected", expq.size() != 0, 1);
                        if (expq.size() != 0) begin
                            e = expq.pop_front();
                            chk("wr_addr", bus.mem_addr, e.a);
                            chk("wr_data", bus.mem_dataout, e.d);
                        end
                        chk("we_sel_busy", {bus.mem_sel, busy}, 2'b11);
                        mem[bus.mem_addr]  = bus.mem_dataout;
                        wgen[bus.mem_addr] = gen;
                    end else begin
                        chk("bus_quiet", {bus.mem_addr, bus.mem_dataout}, 0);
                    end
                    if (cpu_start) begin
                        n_pulse++;
                        chk("start_expected", n_start > 0, 1);
                        chk("start_latency", prev_we, 1);
                        chk("start_sel", bus.mem_sel, 0);
                        if (n_start > 0) n_start--;
                        if (err_pend) exp_err = 1'b1;
                        err_pend = 1'b0;
                    end
                    chk("err_overflow", err_overflow, exp_err);
                    if (exp_halted)
                        chk("halted_outs", {done, busy, bus.inst_ready}, 3'b100);
                    prev_we = bus.mem_we;
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog expired t=%0t", $time);
                $fatal(1, "watchdog");
            end
        join_none

        cyc(3);
        chk("rst_state", {busy, done, err_overflow, cpu_start,
                          bus.inst_ready, bus.mem_we, bus.mem_sel}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Three-word burst, preceded by an idle stretch in WAIT_DATA.
        gen++;
        p0 = n_pulse;
        start_burst();
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("r38_ready", bus.inst_ready, 1);
            chk("r38_no_we", bus.mem_we, 0);
            chk("r38_no_start", cpu_start, 0);
        end
        cyc(1);
        send(16'h1234, 1'b0, 20, ok); chk("r37_acc1", ok, 1);
        send(16'h5678, 1'b0, 20, ok); chk("r37_acc2", ok, 1);
        send(16'h9ABC, 1'b1, 20, ok); chk("r37_acc3", ok, 1);
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            chk("r37_byte", mem[BASE + i], exp37[i]);
            chk("r37_written", wgen[BASE + i] == gen, 1);
        end
        chk("r37_pulses", n_pulse - p0, 1);
        chk("r37_err", err_overflow, 0);

        // Single word, last.
        do_reset();
        gen++;
        start_burst();
        send(16'hABCD, 1'b1, 20, ok); chk("single_acc", ok, 1);
        wait_idle();
        chk("single_b0", mem[BASE], 8'hCD);
        chk("single_b1", mem[BASE + 1], 8'hAB);
`ifdef RELOAD_HALT_APPEND_EN
        chk("halt_b2", mem[BASE + 2], 8'h00);
        chk("halt_b3", mem[BASE + 3], 8'h08);
        chk("halt_written", wgen[BASE + 3] == gen, 1);
`else
        chk("no_append", wgen[BASE + 2] == gen, 0);
`endif

        // Random bursts with ignored nxt activity while busy.
        do_reset();
        for (int b = 0; b < 40; b++) begin
            hl = ($urandom_range(0, 3) != 0);
            if (hl) len = $urandom_range(1, MAXW + 1);
            else len = MAXW + $urandom_range(0, 1);
            start_burst();
            for (int i = 0; i < len && i < MAXW; i++) begin
                lst = hl && (i == len - 1);
                if ($urandom_range(0, 7) == 0) begin
                    nxt = 2'($urandom_range(1, 3));
                    cyc(1);
                    nxt = 2'b00;
                end
                cyc($urandom_range(0, 2));
                send(16'($urandom), lst, 20, ok);
                chk("rnd_accept", ok, 1);
            end
            wait_idle();
        end

        // Overflow: seventeen words, none marked last.
        do_reset();
        gen++;
        p0 = n_pulse;
        start_burst();
        for (int i = 0; i < MAXW; i++) begin
            send(16'hA000 + 16'(i), 1'b0, 20, ok);
            chk("r39_accept", ok, 1);
        end
        send(16'hFFFF, 1'b0, 12, ok);
        chk("r39_w17_rejected", ok, 0);
        wait_idle();
        cnt = 0;
        for (int a = BASE; a < BASE + 32; a++) if (wgen[a] == gen) cnt++;
        chk("r39_bytes", cnt, 32);
        chk("r39_no_extra", wgen[BASE + 32] == gen, 0);
        chk("r39_b0", mem[BASE], 8'h00);
        chk("r39_b31", mem[BASE + 31], 8'hA0);
        chk("r39_err", err_overflow, 1);
        chk("r39_pulses", n_pulse - p0, 1);

        // Reset while the high byte of the second word is being written.
        do_reset();
        gen++;
        start_burst();
        send(16'h1111, 1'b0, 20, ok); chk("r41_acc1", ok, 1);
        send(16'h2222, 1'b0, 20, ok); chk("r41_acc2", ok, 1);
        cyc(1);
        chk("r41_in_wr_hi", {bus.mem_we, bus.mem_addr}, {1'b1, AW'(BASE + 3)});
        rst_n = 1'b0;
        #1;
        chk("r41_async_zero", {bus.mem_we, bus.mem_sel, bus.mem_addr,
                               bus.mem_dataout, busy, cpu_start}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("r41_idle", {busy, done, bus.inst_ready}, 0);
        chk("r41_w1_lo", mem[BASE], 8'h11);
        chk("r41_w1_hi", mem[BASE + 1], 8'h11);
        chk("r41_w2_hi_absent", wgen[BASE + 3] == gen, 0);

        // Finish request wins over a simultaneous reload edge; HALTED is sticky.
        gen++;
        nxt = 2'b11;
        cyc(1);
        exp_halted = 1'b1;
        nxt = 2'b00;
        cyc(3);
        nxt = 2'b10;
        cyc(1);
        nxt = 2'b00;
        send(16'h5555, 1'b1, 8, ok);
        chk("r40_no_accept", ok, 0);
        chk("r40_done", done, 1);
        chk("r40_no_writes", wgen[BASE] == gen, 0);
        do_reset();
        chk("r40_reset_exit", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_reload_ctrl.md
INST_RELOAD_CTRL -- requirements
Module: inst_reload_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, memory byte-address width.
REQ-002 Parameter BASE_ADDR, default 500, byte address of the first reloaded instruction (PC 250 x 2).
REQ-003 Parameter MAX_WORDS, default 16, maximum 16-bit instructions per reload burst.
REQ-004 Parameter HALT_WORD, default 16'h0800, instruction word appended when RELOAD_HALT_APPEND_EN is defined.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 nxt  input  2  CPU status: bit1 = instructions exhausted (reload request), bit0 = program finished.
REQ-008 inst_valid  input  1  upstream instruction word valid.
REQ-009 inst_data  input  16  upstream instruction word.
REQ-010 inst_last  input  1  qualifies inst_data as final word of burst.
REQ-011 inst_ready  output  1  block accepts inst_data this cycle.
REQ-012 mem_sel  output  1  1 = block owns the memory port; 0 = CPU owns it.
REQ-013 mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-014 mem_dataout  output  8  memory write byte.
REQ-015 mem_we  output  1  memory write enable, one byte per cycle.
REQ-016 cpu_start  output  1  one-cycle start pulse to CPU.
REQ-017 busy  output  1  high in any state except IDLE and HALTED.
REQ-018 done  output  1  high in HALTED.
REQ-019 err_overflow  output  1  sticky: burst exceeded MAX_WORDS.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_DATA, WR_LO, WR_HI, START, HALTED.
REQ-021 A registered copy of nxt[1] SHALL detect its rising edge; only a rising edge in IDLE moves to WAIT_DATA and clears the word counter to 0.
REQ-022 nxt[0] high in IDLE SHALL move to HALTED, which is left only by reset; nxt[0] has priority over a simultaneous nxt[1] edge.
REQ-023 nxt edges outside IDLE SHALL be ignored.
REQ-024 inst_ready SHALL be 1 only in WAIT_DATA; on inst_valid&inst_ready the word and inst_last are latched and the FSM goes to WR_LO next cycle.
REQ-025 WR_LO SHALL assert mem_we with mem_addr = BASE_ADDR + 2*cnt and mem_dataout = word[7:0].
REQ-026 WR_HI SHALL assert mem_we with mem_addr = BASE_ADDR + 2*cnt + 1, mem_dataout = word[15:8], then increment cnt.
REQ-027 After WR_HI: latched last -> START (or append, REQ-035); cnt reaching MAX_WORDS without last -> set err_overflow, go to START; otherwise -> WAIT_DATA.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-029 mem_sel SHALL be 1 in WAIT_DATA, WR_LO, WR_HI; 0 elsewhere, including START.
REQ-030 START SHALL assert cpu_start for exactly one cycle, then go to IDLE.
REQ-031 Per accepted word, minimum 3 cycles (accept, WR_LO, WR_HI); last WR_HI to cpu_start pulse = 1 cycle.
REQ-032 mem_we, mem_addr, mem_dataout SHALL be 0 when mem_we is not asserted.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, cnt=0, captured nxt[1] = 0, and all outputs 0, including err_overflow, even mid-burst; a partially written word is not completed.

Configuration
REQ-034 Macro RELOAD_HALT_APPEND_EN selects the HALT-append feature.
REQ-035 Defined: after the last word, if cnt < MAX_WORDS, HALT_WORD is written at the next two byte addresses (WR_LO/WR_HI, no handshake) before START; if cnt == MAX_WORDS, no append and err_overflow is set.
REQ-036 Not defined: no append; last word goes directly to START.

Verification
REQ-037 Reset, nxt=2'b10 edge, 3 words 16'h1234/16'h5678/16'h9ABC (last on third) -> bytes 34,12,78,56,BC,9A at 500..505, one cpu_start pulse, err_overflow=0.
REQ-038 inst_valid held low 5 cycles in WAIT_DATA -> inst_ready stays 1, mem_we stays 0, no cpu_start.
REQ-039 17 words with no inst_last, MAX_WORDS=16 -> 32 bytes written at 500..531, err_overflow=1, cpu_start pulses, 17th word not accepted.
REQ-040 nxt=2'b11 asserted in IDLE -> HALTED, done=1, no further writes on later nxt[1] edges.
REQ-041 rst_n low during WR_HI of second word -> all outputs 0 at once, IDLE after release, only first word in memory.
REQ-042 With RELOAD_HALT_APPEND_EN, single word 16'hABCD last -> bytes CD,AB,00,08 at 500..503, then cpu_start.
